// File: rtl/uart_scan_pkg.sv
// uart_scan_pkg: command/status bytes and controller state encoding
package uart_scan_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_PING  = 8'h03;
  localparam logic [7:0] ST_ACK    = 8'hAC;
  localparam logic [7:0] ST_PONG   = 8'h5A;
  localparam logic [7:0] ST_NAK    = 8'hEE;
  typedef enum logic [2:0] {
    IDLE,
    RECV,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE,
    RESP
  } state_e;
endpackage

// File: rtl/scan_byte_shifter.sv
// scan_byte_shifter: byte register, bit index and half-period divider for scan shifting
module scan_byte_shifter
  import uart_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic [3:0] nbits,
  input  logic       run,
  input  logic       hi,
  output logic       tick,
  output logic       done,
  output logic       next_bit
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nbits_q, nbits_d;
  logic          last;

  always_comb begin
    last     = {1'b0, idx_q} == nbits_q - 4'd1;
    tick     = run && div_q == DW'(SCAN_DIV - 1);
    done     = tick && hi && last;
    next_bit = byte_q[idx_q + 3'd1];
    div_d    = (load || !run || tick) ? '0 : div_q + DW'(1);
    idx_d    = load ? 3'd0 : (tick && hi && !last) ? idx_q + 3'd1 : idx_q;
    byte_d   = load ? data : byte_q;
    nbits_d  = load ? nbits : nbits_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      nbits_q <= '0;
    end else begin
      div_q   <= div_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      nbits_q <= nbits_d;
    end
  end
endmodule

// File: rtl/uart_scan_ctrl.sv
// uart_scan_ctrl: UART command sequencer driving the scan chain and returning a status byte
module uart_scan_ctrl
  import uart_scan_pkg::*;
#(
  parameter int SCAN_LEN       = 512,
  parameter int SCAN_DIV       = 4,
  parameter int TIMEOUT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       scan_clk,
  output logic       scan_in,
  output logic       scan_update,
  output logic       busy
);
  localparam int BW = $clog2(SCAN_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [BW-1:0] rem_q, rem_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          scan_clk_q, scan_clk_d;
  logic          scan_in_q, scan_in_d;
  logic          scan_update_q, scan_update_d;
  logic          rx_hs, load, sh_run, sh_hi, sh_tick, sh_done, sh_next_bit;
  logic [3:0]    nbits;

  always_comb begin
    rx_ready    = !reset && (state_q == IDLE || state_q == RECV);
    busy        = state_q != IDLE;
    rx_hs       = rx_valid && rx_ready;
    load        = rx_hs && state_q == RECV;
    nbits       = 32'(rem_q) >= 8 ? 4'd8 : 4'(rem_q);
    sh_run      = state_q == SHIFT_LO || state_q == SHIFT_HI || state_q == UPDATE;
    sh_hi       = state_q == SHIFT_HI;
    tx_data     = tx_data_q;
    tx_valid    = tx_valid_q;
    scan_clk    = scan_clk_q;
    scan_in     = scan_in_q;
    scan_update = scan_update_q;
  end

  scan_byte_shifter #(.SCAN_DIV(SCAN_DIV)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (rx_data),
    .nbits    (nbits),
    .run      (sh_run),
    .hi       (sh_hi),
    .tick     (sh_tick),
    .done     (sh_done),
    .next_bit (sh_next_bit)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    rem_d     = rem_q;
    to_d      = (state_q == RECV && !rx_hs) ? to_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (rx_hs) begin
        state_d   = rx_data == CMD_WRITE ? RECV : RESP;
        tx_data_d = rx_data == CMD_WRITE ? tx_data_q : rx_data == CMD_PING ? ST_PONG : ST_NAK;
        rem_d     = BW'(SCAN_LEN);
      end
      RECV: if (load) begin
        state_d = SHIFT_LO;
        rem_d   = rem_q - BW'(nbits);
      end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = RESP;
        tx_data_d = ST_NAK;
      end
      SHIFT_LO: state_d = sh_tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (sh_tick) state_d = !sh_done ? SHIFT_LO : rem_q == '0 ? UPDATE : RECV;
      UPDATE: if (sh_tick) begin
        state_d   = RESP;
        tx_data_d = ST_ACK;
      end
      RESP: state_d = tx_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    tx_valid_d    = state_d == RESP;
    scan_clk_d    = state_d == SHIFT_HI;
    scan_update_d = state_d == UPDATE;
    scan_in_d     = (state_d == SHIFT_LO && state_q == RECV) ? rx_data[0] :
                    (state_d == SHIFT_LO && state_q == SHIFT_HI) ? sh_next_bit : scan_in_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      to_q          <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      scan_clk_q    <= 1'b0;
      scan_in_q     <= 1'b0;
      scan_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      to_q          <= to_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      scan_clk_q    <= scan_clk_d;
      scan_in_q     <= scan_in_d;
      scan_update_q <= scan_update_d;
    end
  end
endmodule

// File: tb/tb_uart_scan_ctrl.sv
// tb_uart_scan_ctrl: scoreboard bench for the UART scan controller
module tb_uart_scan_ctrl;
  localparam int SCAN_LEN = 12;
  localparam int SCAN_DIV = 2;
  localparam int TIMEOUT = 50;
  localparam int CHAIN_BYTES = (SCAN_LEN + 7) / 8;
  localparam logic [7:0] C_WRITE = 8'h01, C_PING = 8'h03;
  localparam logic [7:0] R_ACK = 8'hAC, R_PONG = 8'h5A, R_NAK = 8'hEE;

  typedef struct packed { logic v; logic first; } bit_t;
  typedef struct packed { logic [7:0] v; int lat; } rsp_t;

  logic clk = 0, reset = 1, rx_valid = 0, tx_ready = 1;
  logic [7:0] rx_data = 0;
  logic rx_ready, tx_valid, scan_clk, scan_in, scan_update, busy;
  logic [7:0] tx_data;

  int vectors = 0, miscompares = 0;
  int cyc = 0, hs_cyc = 0, rises = 0, upd_run = 0, upd_falls = 0, exp_upd = 0, tx_rise_cyc = 0;
  logic [31:0] cap = 0;
  bit_t exp_bits[$];
  rsp_t exp_tx[$];
  logic p_rst = 1, p_clk = 0, p_in = 0, p_upd = 0, p_valid = 0, p_ready = 0;
  logic [7:0] p_data = 0;

  uart_scan_ctrl #(.SCAN_LEN(SCAN_LEN), .SCAN_DIV(SCAN_DIV), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .scan_clk(scan_clk),
    .scan_in(scan_in), .scan_update(scan_update), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  task automatic monitor();
    bit_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset || p_rst) begin
        upd_run = 0;
      end else begin
        if (rx_valid && rx_ready) hs_cyc = cyc + 1;
        if (rx_valid && tx_valid) chk("rx_blocked_during_resp", rx_ready, 0);
        if (scan_clk && !p_clk) begin
          rises++;
          cap = {cap[30:0], scan_in};
          if (exp_bits.size() == 0) fail("unexpected_scan_clk_rise");
          else begin
            b = exp_bits.pop_front();
            chk("scan_in_bit", scan_in, b.v);
            if (b.first) chk("first_rise_latency", cyc - hs_cyc, SCAN_DIV);
          end
        end
        if (scan_in != p_in) chk("scan_in_changed_with_clk_high", scan_clk, 0);
        if (scan_update) begin
          upd_run++;
          chk("scan_clk_during_update", scan_clk, 0);
        end
        if (!scan_update && p_upd) begin
          upd_falls++;
          chk("update_length", upd_run, SCAN_DIV);
          chk("tx_valid_after_update", tx_valid, 1);
          chk("update_expected", exp_upd > 0, 1);
          exp_upd--;
          upd_run = 0;
        end
        if (p_valid && !p_ready) begin
          chk("tx_valid_held", tx_valid, 1);
          chk("tx_data_held", tx_data, p_data);
        end
        if (tx_valid && !p_valid) tx_rise_cyc = cyc;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) fail("unexpected_tx_byte");
          else begin
            r = exp_tx.pop_front();
            chk("tx_data", tx_data, r.v);
            if (r.lat >= 0) chk("tx_latency", tx_rise_cyc - hs_cyc, r.lat);
          end
        end
      end
      p_rst = reset; p_clk = scan_clk; p_in = scan_in; p_upd = scan_update;
      p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_scan_clk", scan_clk, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_scan_update", scan_update, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    int n = 0;
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    while (!rx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      fail("rx_byte_never_accepted");
      rx_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) rx_valid = 0;
  endtask

  task automatic expect_bits(input logic [8*CHAIN_BYTES-1:0] pay, input int n);
    for (int k = 0; k < n; k++) exp_bits.push_back(bit_t'{v: pay[k], first: (k % 8 == 0)});
  endtask

  task automatic expect_write(input logic [8*CHAIN_BYTES-1:0] pay);
    expect_bits(pay, SCAN_LEN);
    exp_tx.push_back(rsp_t'{v: R_ACK, lat: -1});
    exp_upd++;
  endtask

  task automatic wait_resp(input bit rnd);
    int n = 0;
    while (exp_tx.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      tx_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      n++;
    end
    if (exp_tx.size() != 0) fail("response_wait_expired");
    tx_ready = 1;
    @(posedge clk);
    #1;
    chk("idle_after_resp", busy, 0);
  endtask

  initial begin
    logic [8*CHAIN_BYTES-1:0] pay;
    logic [7:0] b;
    int r0, u0, cnt, gap, n;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    reset = 0;
    @(posedge clk);
    #1;
    chk("rx_ready_after_reset", rx_ready, 1);

    r0 = rises;
    exp_tx.push_back(rsp_t'{v: R_PONG, lat: -1});
    send_byte(C_PING, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    chk("ping_valid_cycles", cnt, 1);
    chk("ping_no_scan_clk", rises - r0, 0);
    wait_resp(0);

    r0 = rises;
    pay = 16'h0A34;
    expect_write(pay);
    send_byte(C_WRITE, 0);
    send_byte(8'h34, 0);
    send_byte(8'h0A, 0);
    wait_resp(0);
    chk("write_rises", rises - r0, 12);
    chk("write_bit_sequence", cap[11:0], 12'b0010_1100_0101);

    tx_ready = 0;
    exp_tx.push_back(rsp_t'{v: R_NAK, lat: -1});
    send_byte(8'h7F, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("nak_valid_while_stalled", tx_valid, 1);
    wait_resp(0);

    u0 = upd_falls;
    expect_bits(16'h0034, 8);
    exp_tx.push_back(rsp_t'{v: R_NAK, lat: 2 * SCAN_DIV * 8 + TIMEOUT});
    send_byte(C_WRITE, 0);
    send_byte(8'h34, 0);
    wait_resp(0);
    chk("timeout_no_update", upd_falls - u0, 0);

    r0 = rises;
    u0 = upd_falls;
    expect_write(16'h0F5B);
    send_byte(C_WRITE, 0);
    send_byte(8'h5B, 0);
    n = 0;
    while (rises - r0 < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_fifth_bit", rises - r0 >= 5, 1);
    reset = 1;
    exp_bits.delete();
    exp_tx.delete();
    exp_upd = 0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    reset = 0;
    @(posedge clk);
    #1;
    chk("reset_no_update", upd_falls - u0, 0);
    exp_tx.push_back(rsp_t'{v: R_PONG, lat: -1});
    send_byte(C_PING, 0);
    wait_resp(0);

    pay = 16'h0C96;
    expect_write(pay);
    exp_tx.push_back(rsp_t'{v: R_PONG, lat: -1});
    send_byte(C_WRITE, 1);
    send_byte(pay[7:0], 1);
    send_byte(pay[15:8], 1);
    send_byte(C_PING, 0);
    wait_resp(0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          exp_tx.push_back(rsp_t'{v: R_PONG, lat: -1});
          send_byte(C_PING, 0);
        end
        1, 2: begin
          pay = (8 * CHAIN_BYTES)'($urandom);
          expect_write(pay);
          send_byte(C_WRITE, 0);
          for (int k = 0; k < CHAIN_BYTES; k++) begin
            gap = $urandom_range(0, 8);
            repeat (gap) @(posedge clk);
            #1;
            send_byte(pay[8*k+:8], 0);
          end
        end
        default: begin
          b = 8'($urandom);
          if (b == C_WRITE || b == C_PING) b = 8'hC3;
          exp_tx.push_back(rsp_t'{v: R_NAK, lat: -1});
          send_byte(b, 0);
        end
      endcase
      wait_resp(1);
    end

    chk("bits_drained", exp_bits.size(), 0);
    chk("updates_drained", exp_upd, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
